// File: rtl/accel_pkg.sv
// Shared types and constants for the SRAM read-side streaming path.
// The SRAM geometry sets the default widths of the streamer and its output buffer.
package accel_pkg;

  localparam int SRAM_DEPTH        = 512;
  localparam int SRAM_DATA_W       = 128;
  localparam int SRAM_ADDR_W       = $clog2(SRAM_DEPTH);
  localparam int STREAM_FIFO_DEPTH = 2;

  typedef logic [SRAM_DATA_W-1:0] sram_word_t;
  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
  typedef logic [SRAM_ADDR_W:0]   word_cnt_t;

  typedef struct packed {
    logic       last;
    sram_word_t data;
  } stream_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } streamer_state_t;

  function automatic sram_addr_t burst_addr(input sram_addr_t base, input word_cnt_t idx);
    return base + idx[SRAM_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small first-word-fall-through buffer holding {last, data} entries.
// The head entry is visible on o_data whenever o_empty is low.
module stream_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A pop on an empty buffer is dropped so the pointers can never cross.
  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/sram_read_streamer.sv
// Bursts reads out of a 1r1w SRAM read port and re-times the returned words into a
// valid/ready stream; a read is only issued when buffer space for its data is guaranteed.
module sram_read_streamer
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_W,
  parameter int ADDR_WIDTH = SRAM_ADDR_W,
  parameter int FIFO_DEPTH = STREAM_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sram_csb,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  input  logic [DATA_WIDTH-1:0] i_sram_dout,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  streamer_state_t       r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_num;
  logic [ADDR_WIDTH:0]   r_issued_cnt;
  logic [ADDR_WIDTH:0]   r_popped_cnt;
  logic                  r_pending;
  logic                  r_pending_last;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_issue;
  logic [OCC_W-1:0]      w_occupancy;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH:0]   w_fifo_head;

  assign w_pop = o_out_valid && i_out_ready;

  // Words already buffered plus the one in flight, less the one leaving this cycle.
  assign w_occupancy = OCC_W'(w_fifo_count) + OCC_W'(r_pending) - OCC_W'(w_pop);

  assign w_issue = rst_n
                && (r_state == ST_RUN)
                && (w_occupancy < OCC_W'(FIFO_DEPTH))
                && (r_issued_cnt < r_num);

  assign w_last_issue = w_issue && ((r_issued_cnt + CNT_ONE) == r_num);

  assign o_sram_csb  = !w_issue;
  assign o_sram_addr = w_issue ? (r_base + r_issued_cnt[ADDR_WIDTH-1:0]) : '0;

  // dout is only valid in the cycle after the read, so it is captured on that edge.
  stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_pending),
    .i_data  ({r_pending_last, i_sram_dout}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_out_valid = !w_fifo_empty;
  assign o_out_data  = w_fifo_head[DATA_WIDTH-1:0];
  assign o_out_last  = o_out_valid && w_fifo_head[DATA_WIDTH];
  assign o_busy      = r_busy;
  assign o_done      = r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_base         <= '0;
      r_num          <= '0;
      r_issued_cnt   <= '0;
      r_popped_cnt   <= '0;
      r_pending      <= 1'b0;
      r_pending_last <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_pending      <= w_issue;
      r_pending_last <= w_last_issue;
      r_done         <= 1'b0;
      if (w_issue) begin
        r_issued_cnt <= r_issued_cnt + CNT_ONE;
      end
      if (w_pop) begin
        r_popped_cnt <= r_popped_cnt + CNT_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_base       <= i_base_addr;
            r_num        <= i_num_words;
            r_issued_cnt <= '0;
            r_popped_cnt <= '0;
            r_busy       <= 1'b1;
            if (i_num_words == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_last_issue) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && o_out_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  a_no_capture_into_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(r_pending && w_fifo_full)
  );

  a_last_is_final_word: assert property (
    @(posedge clk) disable iff (!rst_n)
    (w_pop && o_out_last) |-> (r_popped_cnt == (r_num - CNT_ONE))
  );

endmodule
